// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: state encodings,
// access-size codes and the data/tag widths used across the slice.
package mem_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_SIZE_WIDTH = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_FETCH = 3'd1,
    ARB_LOAD  = 3'd2,
    ARB_STORE = 3'd3,
    ARB_DRAIN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetcher, LSB and memory-engine signals around the arbiter.
// The slave modport is the arbiter's view; master is the requesters/engine side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Requests are level signals held until the matching done pulse;
  // arb_mem_valid is held with stable payload until the engine pulses mem_done.
  logic                      fet_req;
  logic [XLEN-1:0]           fet_addr;
  logic                      lsb_req;
  logic                      lsb_we;
  logic [1:0]                lsb_size;
  logic [XLEN-1:0]           lsb_addr;
  logic [XLEN-1:0]           lsb_wdata;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id;
  logic                      mem_done;
  logic [XLEN-1:0]           mem_rdata;
  logic                      arb_mem_valid;
  logic                      arb_mem_we;
  logic [1:0]                arb_mem_size;
  logic [XLEN-1:0]           arb_mem_addr;
  logic [XLEN-1:0]           arb_mem_wdata;
  logic                      arb_fet_done;
  logic [XLEN-1:0]           arb_fet_data;
  logic                      arb_lsb_done;
  logic [XLEN-1:0]           arb_lsb_data;
  logic [ROB_SIZE_WIDTH-1:0] arb_lsb_id;

  modport slave (
    input  fet_req, fet_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
           lsb_id, mem_done, mem_rdata,
    output arb_mem_valid, arb_mem_we, arb_mem_size, arb_mem_addr, arb_mem_wdata,
           arb_fet_done, arb_fet_data, arb_lsb_done, arb_lsb_data, arb_lsb_id
  );

  modport master (
    output fet_req, fet_addr, lsb_req, lsb_we, lsb_size, lsb_addr, lsb_wdata,
           lsb_id, mem_done, mem_rdata,
    input  arb_mem_valid, arb_mem_we, arb_mem_size, arb_mem_addr, arb_mem_wdata,
           arb_fet_done, arb_fet_data, arb_lsb_done, arb_lsb_data, arb_lsb_id
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating counter of LSB wins over a waiting fetch; hit_o flags the limit.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory engine between fetcher and LSB, one transaction at a time.
// Defining MEM_ARBITER_STATS_EN adds grant and wait-cycle statistics outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  mem_arbiter_if.slave         bus,
  output arb_state_e           state_o,
  output logic [CNT_WIDTH-1:0] starve_cnt_o
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]          stat_fet_grants,
  output logic [31:0]          stat_lsb_grants,
  output logic [31:0]          stat_wait_cycles
`endif
);

  arb_state_e                state_q, state_d;
  logic                      mem_valid_q, mem_valid_d;
  logic                      mem_we_q, mem_we_d;
  logic [1:0]                mem_size_q, mem_size_d;
  logic [XLEN-1:0]           mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]           mem_wdata_q, mem_wdata_d;
  logic [ROB_SIZE_WIDTH-1:0] cur_id_q, cur_id_d;
  logic                      fet_done_q, fet_done_d;
  logic [XLEN-1:0]           fet_data_q, fet_data_d;
  logic                      lsb_done_q, lsb_done_d;
  logic [XLEN-1:0]           lsb_data_q, lsb_data_d;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id_q, lsb_id_d;

  logic store_req, load_req;
  logic grant_fet, grant_lsb;
  logic starve_hit, starve_inc, starve_clr;

  // Stores are never speculative, so they may still win while a flush is asserted.
  always_comb begin
    store_req = bus.lsb_req & bus.lsb_we;
    load_req  = bus.lsb_req & ~bus.lsb_we;
    grant_fet = 1'b0;
    grant_lsb = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (store_req) begin
        grant_lsb = 1'b1;
      end else if (!flush) begin
        if (bus.fet_req && starve_hit) begin
          grant_fet = 1'b1;
        end else if (load_req) begin
          grant_lsb = 1'b1;
        end else if (bus.fet_req) begin
          grant_fet = 1'b1;
        end
      end
    end
  end

  assign starve_inc = grant_lsb & bus.fet_req;
  assign starve_clr = grant_fet | flush | ((state_q == ARB_IDLE) & ~bus.fet_req);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (CNT_WIDTH)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rdy),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .cnt_o (starve_cnt_o),
    .hit_o (starve_hit)
  );

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cur_id_d    = cur_id_q;
    fet_done_d  = 1'b0;
    fet_data_d  = fet_data_q;
    lsb_done_d  = 1'b0;
    lsb_data_d  = lsb_data_q;
    lsb_id_d    = lsb_id_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_fet) begin
          state_d     = ARB_FETCH;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = SIZE_WORD;
          mem_addr_d  = bus.fet_addr;
          mem_wdata_d = '0;
        end else if (grant_lsb) begin
          state_d     = bus.lsb_we ? ARB_STORE : ARB_LOAD;
          mem_valid_d = 1'b1;
          mem_we_d    = bus.lsb_we;
          mem_size_d  = bus.lsb_size;
          mem_addr_d  = bus.lsb_addr;
          mem_wdata_d = bus.lsb_wdata;
          cur_id_d    = bus.lsb_id;
        end
      end

      // The engine cannot abort, so a flushed read keeps valid up until its done.
      ARB_FETCH, ARB_LOAD: begin
        if (flush) begin
          if (bus.mem_done) begin
            state_d     = ARB_IDLE;
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
          end else begin
            state_d = ARB_DRAIN;
          end
        end else if (bus.mem_done) begin
          state_d     = ARB_IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          if (state_q == ARB_FETCH) begin
            fet_done_d = 1'b1;
            fet_data_d = bus.mem_rdata;
          end else begin
            lsb_done_d = 1'b1;
            lsb_data_d = bus.mem_rdata;
            lsb_id_d   = cur_id_q;
          end
        end
      end

      ARB_STORE: begin
        if (bus.mem_done) begin
          state_d     = ARB_IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
          lsb_done_d  = 1'b1;
          lsb_data_d  = '0;
          lsb_id_d    = cur_id_q;
        end
      end

      ARB_DRAIN: begin
        if (bus.mem_done) begin
          state_d     = ARB_IDLE;
          mem_valid_d = 1'b0;
          mem_we_d    = 1'b0;
        end
      end

      default: begin
        state_d     = ARB_IDLE;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cur_id_q    <= '0;
      fet_done_q  <= 1'b0;
      fet_data_q  <= '0;
      lsb_done_q  <= 1'b0;
      lsb_data_q  <= '0;
      lsb_id_q    <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cur_id_q    <= cur_id_d;
      fet_done_q  <= fet_done_d;
      fet_data_q  <= fet_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_data_q  <= lsb_data_d;
      lsb_id_q    <= lsb_id_d;
    end
  end

  assign state_o           = state_q;
  assign bus.arb_mem_valid = mem_valid_q;
  assign bus.arb_mem_we    = mem_we_q;
  assign bus.arb_mem_size  = mem_size_q;
  assign bus.arb_mem_addr  = mem_addr_q;
  assign bus.arb_mem_wdata = mem_wdata_q;
  assign bus.arb_fet_done  = fet_done_q;
  assign bus.arb_fet_data  = fet_data_q;
  assign bus.arb_lsb_done  = lsb_done_q;
  assign bus.arb_lsb_data  = lsb_data_q;
  assign bus.arb_lsb_id    = lsb_id_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] stat_fet_q, stat_lsb_q, stat_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fet_q  <= '0;
      stat_lsb_q  <= '0;
      stat_wait_q <= '0;
    end else if (rdy) begin
      stat_fet_q <= stat_fet_q + 32'(grant_fet);
      stat_lsb_q <= stat_lsb_q + 32'(grant_lsb);
      if ((bus.fet_req || bus.lsb_req) && (state_q != ARB_IDLE)) begin
        stat_wait_q <= stat_wait_q + 32'd1;
      end
    end
  end

  assign stat_fet_grants  = stat_fet_q;
  assign stat_lsb_grants  = stat_lsb_q;
  assign stat_wait_cycles = stat_wait_q;
`endif

endmodule
